// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the button arbiter and its single consumer.
// The arbiter (master) offers evt_id while evt_valid is high; the consumer
// (slave) answers with evt_ack.
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ack;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ack
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ack
    );
endinterface

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: captures rising edges from N debounced button lines,
// keeps one pending flag per line and offers events one at a time to a
// single consumer over a valid/ack handshake. A press that arrives while the
// same button's event is still unserved sets a sticky overrun flag.
//
// Build option: define BTN_ARB_FIXED_PRIO_EN to select fixed priority
// (lowest pending index wins, no rotation pointer). Left undefined, the
// grant order is round-robin starting after the last served index.
module btn_event_arbiter #(
    parameter int N_BTN = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,        // synchronous, active low
    input  logic [N_BTN-1:0]     btn_db_in,
    input  logic                 ovr_clr,
    btn_event_arbiter_if.master  evt_bus,
    output logic [N_BTN-1:0]     pending,
    output logic [N_BTN-1:0]     evt_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              valid_reg, valid_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [N_BTN-1:0]  prev_reg;
    logic [N_BTN-1:0]  pending_reg, pending_next;
    logic [N_BTN-1:0]  overrun_reg, overrun_next;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  clr;
    logic [ID_W-1:0]   winner;
    logic              any_pending;

`ifndef BTN_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   ptr_reg, ptr_next;
`endif

    // Per-button edge detect, serve-clear and pending/overrun update.
    // A rise on a line whose event is being acked in the same cycle
    // replaces the served event; any other rise on a pending line is lost.
    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            assign rise[gi] = btn_db_in[gi] & ~prev_reg[gi];
            assign clr[gi]  = (state_reg == GRANT) & evt_bus.evt_ack
                              & (id_reg == ID_W'(gi));
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
            // A new drop beats a simultaneous clear request.
            assign overrun_next[gi] = (rise[gi] & pending_reg[gi] & ~clr[gi])
                                    | (overrun_reg[gi] & ~ovr_clr);
        end
    endgenerate

    assign any_pending = |pending_reg;

`ifdef BTN_ARB_FIXED_PRIO_EN
    // Winner select: lowest pending index.
    always_comb begin
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!found && pending_reg[ID_W'(k)]) begin
                winner = ID_W'(k);
                found  = 1'b1;
            end
        end
    end
`else
    // Winner select: scan ptr, ptr+1, ... wrapping at N_BTN; first pending wins.
    // The one-bit-wider sum lets the wrap be a single conditional subtract.
    always_comb begin
        logic            found;
        logic [ID_W:0]   idx_wide;
        logic [ID_W-1:0] idx;
        winner   = '0;
        found    = 1'b0;
        idx_wide = '0;
        idx      = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx_wide = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (idx_wide >= (ID_W+1)'(N_BTN)) begin
                idx_wide = idx_wide - (ID_W+1)'(N_BTN);
            end
            idx = idx_wide[ID_W-1:0];
            if (!found && pending_reg[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    // Grant FSM next-state and handshake outputs. The offered id is frozen
    // for the whole grant; the ack edge always returns to IDLE, so grants
    // are separated by at least one idle cycle.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        id_next    = id_reg;
`ifndef BTN_ARB_FIXED_PRIO_EN
        ptr_next   = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (any_pending) begin
                    id_next    = winner;
                    valid_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (evt_bus.evt_ack) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
`ifndef BTN_ARB_FIXED_PRIO_EN
                    ptr_next   = (id_reg == ID_W'(N_BTN - 1)) ? '0 : id_reg + 1'b1;
`endif
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything, including an active grant;
    // prev_reg takes the live levels so a button held through reset is quiet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            id_reg      <= '0;
            prev_reg    <= btn_db_in;
            pending_reg <= '0;
            overrun_reg <= '0;
`ifndef BTN_ARB_FIXED_PRIO_EN
            ptr_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            id_reg      <= id_next;
            prev_reg    <= btn_db_in;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
`ifndef BTN_ARB_FIXED_PRIO_EN
            ptr_reg     <= ptr_next;
`endif
        end
    end

    assign evt_bus.evt_valid = valid_reg;
    assign evt_bus.evt_id    = id_reg;
    assign pending           = pending_reg;
    assign evt_overrun       = overrun_reg;

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects rising-edge events from N debounced push-button lines (INC, DEC, etc.), holds one pending flag per line, and grants events one at a time to a single consumer over a valid/ack handshake.
- Default grant order is round-robin.
- Sits between the button debouncers and the 16-bit PicoBlaze counter/interrupt logic, so simultaneous presses are serialised rather than lost.
- Also flags presses that arrive while the same button's event is still unserved.

Parameters:
- N_BTN, 4, number of button inputs (2..8).
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= N_BTN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; reset=0 at a clk rising edge clears state.
- btn_db_in  input  N_BTN  debounced, clk-synchronous button levels.
- evt_ack  input  1  consumer accepts the current event; sampled only while evt_valid=1.
- ovr_clr  input  1  clears all evt_overrun bits.
- evt_valid  output  1  an event is being offered.
- evt_id  output  ID_W  index of the offered button; stable while evt_valid=1.
- pending  output  N_BTN  pending flag per button.
- evt_overrun  output  N_BTN  sticky per-button drop flag.

Behaviour:
- Reset (reset=0 at an edge):
  - prev_q <= btn_db_in, so a button held during reset generates no event.
  - pending, evt_overrun, evt_valid, evt_id and the priority pointer ptr all go to 0.
  - FSM goes to IDLE.
  - Reset overrides every other input in the same cycle, including mid-grant: the offered event is dropped with no ack required.
- Edge detect: rise[i] = btn_db_in[i] & ~prev_q[i]. prev_q <= btn_db_in every cycle.
- Pending update, per bit i, evaluated at each edge (rules are exclusive):
  - clr[i] = (state==GRANT) & evt_ack & (evt_id==i).
  - rise[i] & ~pending[i]: pending[i] <= 1.
  - rise[i] & pending[i] & clr[i]: pending[i] stays 1 (the new event replaces the served one); no overrun.
  - rise[i] & pending[i] & ~clr[i]: event dropped; evt_overrun[i] <= 1; pending[i] stays 1.
  - ~rise[i] & clr[i]: pending[i] <= 0.
- evt_overrun:
  - ovr_clr=1 clears all bits.
  - If ovr_clr and a new overrun coincide on a bit, the set wins.
- FSM, two states:
  - IDLE: if any pending bit is set, select winner w, load evt_id <= w, evt_valid <= 1, go to GRANT. Otherwise stay, with evt_valid=0.
  - GRANT: hold evt_id and evt_valid. On evt_ack=1: evt_valid <= 0, ptr <= (w+1) mod N_BTN, go to IDLE.
  - No timeout; the grant is held indefinitely until ack.
- Selection: round-robin. Scan indices ptr, ptr+1, … (mod N_BTN); the first index with pending=1 wins.
- Latency:
  - Button rises before edge E0: pending set at E0, evt_valid=1 after E1.
  - Ack sampled at edge Ea: evt_valid=0 after Ea.
  - Next grant no earlier than after Ea+1, so there is always at least one idle cycle between grants.
- evt_ack while evt_valid=0 is ignored.
- Edges arriving during GRANT on other buttons set their pending bits normally.

Optional Feature:
- Macro BTN_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest pending index always wins; ptr is not implemented and evt_id depends only on pending.
- Undefined: round-robin as above.
- Everything else is identical in both builds: handshake, overrun and reset behaviour.

Test Plan:
1. Reset with btn_db_in=4'b0010 held, then reset=1 for 5 cycles -> pending=0, evt_valid=0 throughout; release and re-press btn1 -> evt_valid=1 two edges later with evt_id=1.
2. btn0 and btn2 rise in the same cycle, ptr=0, ack each grant one cycle after evt_valid -> grants in order id 0 then id 2, with one idle cycle between; pending ends at 0.
3. Round-robin fairness: btn0 and btn1 re-pressed after every grant, acked immediately, 4 grants -> sequence 0,1,0,1. With BTN_ARB_FIXED_PRIO_EN and btn0 re-pressed before every grant -> 0,0,0,0.
4. btn3 pressed, no ack, btn3 released and pressed again -> evt_overrun=4'b1000, pending[3]=1, evt_id stays 3; ovr_clr pulse -> evt_overrun=0.
5. btn1 granted; btn1 re-rises in the same cycle evt_ack=1 -> no overrun, pending[1] stays 1, id 1 is granted again after an idle cycle.
6. Reset pulsed while evt_valid=1 with id 2 -> after that edge evt_valid=0 and pending=0; no grant follows without a new edge.
